// File: rtl/gb80_pkg.sv
// Shared GB80 front-end constants: bus widths, reset vector and fetch FSM encoding.
package gb80_pkg;

    localparam int unsigned GB80_DATA_W   = 8;
    localparam int unsigned GB80_ADDR_W   = 16;
    localparam logic [15:0] GB80_RESET_PC = 16'h0000;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

endpackage

// File: rtl/gb80_fetch_buf.sv
// Prefetch FIFO with flush; head byte and valid are registered so o_data holds when empty.
module gb80_fetch_buf
    import gb80_pkg::*;
#(
    parameter int unsigned  DATA_WIDTH = GB80_DATA_W,
    parameter int unsigned  BUF_DEPTH  = 2,
    localparam int unsigned CNT_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [CNT_W-1:0]      count_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  valid_q, valid_d;
    logic                  do_pop, do_push;

    always_comb begin
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        do_push  = push_i && !flush_i && ((count_q != CNT_W'(BUF_DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end

        valid_d = (count_d != '0);
        // Next head may be the byte being written this very cycle
        if (valid_d) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign data_o  = head_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/gb80_fetch.sv
// GB80 fetch unit: owns fetch address and PC, issues single-outstanding byte reads,
// feeds the decoder from a prefetch buffer and handles redirects with in-flight drop.
module gb80_fetch
    import gb80_pkg::*;
#(
    parameter int unsigned         DATA_WIDTH = GB80_DATA_W,
    parameter int unsigned         PC_WIDTH   = GB80_ADDR_W,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(GB80_RESET_PC),
    parameter int unsigned         BUF_DEPTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rd_en,
    input  logic                  i_pc_load,
    input  logic [PC_WIDTH-1:0]   i_pc_value,
    input  logic                  i_halt,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic                  o_bus_req,
    output logic [PC_WIDTH-1:0]   o_bus_addr,
    input  logic                  i_bus_ack,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    output logic                  o_underflow
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [0:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [PC_WIDTH-1:0] pc_head_q, pc_head_d;
    logic [PC_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic                bus_req_q, bus_req_d;
    logic                drop_q, drop_d;
    logic                underflow_q, underflow_d;

    logic [CNT_W-1:0]    buf_count;
    logic                buf_push, buf_pop, buf_flush;

    gb80_fetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push_i  (buf_push),
        .wdata_i (i_bus_rdata),
        .pop_i   (buf_pop),
        .flush_i (buf_flush),
        .count_o (buf_count),
        .data_o  (o_data),
        .valid_o (o_data_valid)
    );

    // Next-state: PC load outranks pop and ack-write; the FSM keeps at most one read in flight
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        pc_head_d    = pc_head_q;
        bus_addr_d   = bus_addr_q;
        bus_req_d    = bus_req_q;
        drop_d       = drop_q;
        underflow_d  = i_rd_en && (buf_count == '0);
        buf_push     = 1'b0;
        buf_pop      = 1'b0;
        buf_flush    = i_pc_load;

        if (i_pc_load) begin
            pc_head_d    = i_pc_value;
            fetch_addr_d = i_pc_value;
        end else if (i_rd_en && (buf_count != '0)) begin
            buf_pop   = 1'b1;
            pc_head_d = pc_head_q + PC_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!i_halt && !i_pc_load && (buf_count < CNT_W'(BUF_DEPTH))) begin
                    state_d    = S_REQ;
                    bus_req_d  = 1'b1;
                    bus_addr_d = fetch_addr_q;
                end
            end
            S_REQ: begin
                if (i_bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!drop_q && !i_pc_load) begin
                        buf_push     = 1'b1;
                        fetch_addr_d = fetch_addr_q + PC_WIDTH'(1);
                    end
                end else if (i_pc_load) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_PC;
            pc_head_q    <= RESET_PC;
            bus_addr_q   <= RESET_PC;
            bus_req_q    <= 1'b0;
            drop_q       <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_head_q    <= pc_head_d;
            bus_addr_q   <= bus_addr_d;
            bus_req_q    <= bus_req_d;
            drop_q       <= drop_d;
            underflow_q  <= underflow_d;
        end
    end

    assign o_pc        = pc_head_q;
    assign o_bus_req   = bus_req_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_underflow = underflow_q;

endmodule
